rgb_cmp_scheduler: RTL
======================

// Module: rgb_cmp_scheduler
// PURPOSE
//  Shares one 2-bit magnitude comparator with RGB LED output between two requesters.
//  Each requester offers an operand pair (A,B) over a valid/ready handshake.
//  The block round-robin arbitrates the requesters, latches the winning pair and registers
//  the comparator's R/G/B result onto the board LEDs.
//  It then holds the result for DWELL cycles before serving the next request.
//  It sits between the switch/host input logic and the LED pins.
// PARAMETERS
//  DWELL    10                  LED hold time in clk cycles per result; legal range 1..2**16-1
//  DWELL_W  $clog2(DWELL+1)     dwell counter width; derived, not overridden
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset       in   1  asynchronous, active-high reset
//  req0_valid  in   1  requester 0 has an operand pair
//  req0_a      in   2  requester 0 operand A (a1,a0)
//  req0_b      in   2  requester 0 operand B (b1,b0)
//  req0_ready  out  1  requester 0 pair accepted this cycle when valid&ready
//  req1_valid  in   1  as req0_valid, requester 1
//  req1_a      in   2  as req0_a, requester 1
//  req1_b      in   2  as req0_b, requester 1
//  req1_ready  out  1  as req0_ready, requester 1
//  led_r       out  1  A>B result, registered
//  led_g       out  1  A==B result, registered
//  led_b       out  1  A<B result, registered
//  grant_id    out  1  requester whose result is shown; valid while busy
//  busy        out  1  high in LOAD and SHOW
//  done        out  1  one-cycle pulse on the last SHOW cycle
// BEHAVIOUR
//  Reset (async, active-high)
//   - outputs: led_r/g/b=0, grant_id=0, busy=0, done=0, ready=0
//   - state IDLE, dwell counter 0, priority pointer favours req0
//  FSM: IDLE -> LOAD -> SHOW -> IDLE
//   IDLE
//    - ready is combinational and goes to at most one requester.
//    - Only one valid: that requester gets ready.
//    - Both valid: the requester NOT granted last gets ready. After reset this is req0.
//    - On valid&ready: latch A/B, latch grant_id, flip priority pointer, go to LOAD.
//    - No valid: stay in IDLE.
//   LOAD (1 cycle)
//    - cmp2_rgb evaluates the latched pair.
//    - Its result registers onto led_r/g/b at the LOAD->SHOW edge.
//    - Dwell counter loads DWELL-1.
//   SHOW
//    - LEDs held; counter decrements each cycle.
//    - When counter==0: done=1 for that cycle, next state IDLE, LEDs clear to 0 on entry to IDLE.
//  Timing
//   - Latency: handshake at cycle t -> LEDs valid from t+2 for exactly DWELL cycles.
//   - done is high at t+1+DWELL.
//   - Next acceptance is possible at t+2+DWELL.
//  Boundary cases
//   - Both ready lines are 0 in LOAD and SHOW; a valid held while busy waits, nothing is dropped.
//   - Exactly one of led_r/g/b is 1 in SHOW; all are 0 otherwise. Bench asserts this.
//   - DWELL=1: SHOW lasts one cycle, done in that same cycle.
//   - Reset mid-LOAD/SHOW: in-flight pair is discarded and every output reverts at once to its
//     reset value; the requester must re-present.
//   - Operands are unsigned 2-bit values, compare is unsigned, no width extension.
// STRUCTURE
//  rgb_cmp_pkg
//   - typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t
//   - typedef struct packed {logic r, g, b;} rgb_t
//   - localparam OPW = 2
//  cmp2_rgb
//   - one combinational sub-module: (a[1:0], b[1:0]) -> rgb_t, instanced once
//  Top holds: arbiter pointer, operand/grant regs, FSM, dwell counter, LED regs.
// TESTING (DWELL=4 unless noted)
//  1. Only req0 valid, a=2, b=1 at t
//     -> req0_ready=1 at t; led_r=1 at t+2..t+5; done at t+5; grant_id=0.
//  2. req0 (3,3) and req1 (0,2) both valid just after reset
//     -> req0 served first with led_g; then req1 with led_b, grant_id=1, accepted at t+6.
//  3. Both valid continuously for 4 transactions -> grant_id sequence 0,1,0,1; no ready while busy.
//  4. All 16 (a,b) pairs via req1 -> one-hot R/G/B matching a>b / a==b / a<b.
//  5. reset pulsed at SHOW cycle 2
//     -> LEDs/busy/done=0 immediately; next request after release served from req0 priority.
//  6. DWELL=1, req0 (1,3) -> led_b for one cycle; done coincident; ready again the next cycle.

Source files
------------

// File: rtl/rgb_cmp_pkg.sv
// Shared types and constants for the RGB comparator scheduler.
package rgb_cmp_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // One bit per LED: r = A>B, g = A==B, b = A<B.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    // Operand width of the shared comparator.
    localparam int OPW = 2;

    // Number of requesters sharing the comparator.
    localparam int NREQ = 2;

endpackage

// File: rtl/cmp2_rgb.sv
// Unsigned 2-bit magnitude comparator with a one-hot RGB result.
module cmp2_rgb
    import rgb_cmp_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output rgb_t           rgb
);

    // Exactly one of the three relations holds for any unsigned pair.
    always_comb begin
        rgb.r = (a > b);
        rgb.g = (a == b);
        rgb.b = (a < b);
    end

endmodule

// File: rtl/rgb_cmp_scheduler.sv
// Round-robin scheduler sharing one cmp2_rgb between two requesters and
// holding each registered result on the LEDs for DWELL cycles.
module rgb_cmp_scheduler
    import rgb_cmp_pkg::*;
#(
    parameter  int DWELL   = 10,
    localparam int DWELL_W = $clog2(DWELL + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           req1_ready,
    output logic           led_r,
    output logic           led_g,
    output logic           led_b,
    output logic           grant_id,
    output logic           busy,
    output logic           done
);

    state_t               state_reg;
    logic                 prio_reg;      // 0: req0 favoured on a tie, 1: req1 favoured
    logic [OPW-1:0]       a_reg;
    logic [OPW-1:0]       b_reg;
    logic                 grant_reg;
    rgb_t                 led_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [DWELL_W-1:0]   cnt_reg;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic                 accept;
    logic                 winner;
    logic [OPW-1:0]       sel_a;
    logic [OPW-1:0]       sel_b;
    rgb_t                 cmp_rgb;

    assign req_valid = {req1_valid, req0_valid};

    // Ready for each requester: only in IDLE, and on a tie only the favoured one.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            always_comb begin
                req_ready[gi] = 1'b0;
                if (state_reg == IDLE && !reset) begin
                    req_ready[gi] = req_valid[gi] &&
                                    (!req_valid[NREQ-1-gi] || (prio_reg == 1'(gi)));
                end
            end
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // At most one ready is high, so req1's ready alone identifies the winner.
    assign accept = |req_ready;
    assign winner = req_ready[1];
    assign sel_a  = winner ? req1_a : req0_a;
    assign sel_b  = winner ? req1_b : req0_b;

    cmp2_rgb u_cmp (
        .a   (a_reg),
        .b   (b_reg),
        .rgb (cmp_rgb)
    );

    // Scheduler FSM: accept a pair, evaluate it, then hold the LEDs for DWELL cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            grant_reg <= 1'b0;
            led_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        grant_reg <= winner;
                        // The loser of this round is favoured on the next tie.
                        prio_reg  <= ~winner;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    led_reg   <= cmp_rgb;
                    cnt_reg   <= DWELL_W'(DWELL - 1);
                    // With a one-cycle dwell the first SHOW cycle is also the last.
                    done_reg  <= (DWELL == 1);
                    state_reg <= SHOW;
                end
                SHOW: begin
                    if (cnt_reg == '0) begin
                        led_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        done_reg  <= (cnt_reg == DWELL_W'(1));
                    end
                end
                default: begin
                    led_reg   <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign led_r    = led_reg.r;
    assign led_g    = led_reg.g;
    assign led_b    = led_reg.b;
    assign grant_id = grant_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
